// File: rtl/aes_rcon_pkg.sv
// Shared constants and GF(2^8) helpers for the AES round-constant generator.
package aes_rcon_pkg;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;
  localparam logic [1:0] KS_ILL = 2'b11;

  localparam logic [3:0] LEN_128 = 4'd10;
  localparam logic [3:0] LEN_192 = 4'd8;
  localparam logic [3:0] LEN_256 = 4'd7;

  localparam logic [7:0] RCON_INV_128 = 8'h36;
  localparam logic [7:0] RCON_INV_192 = 8'h80;
  localparam logic [7:0] RCON_INV_256 = 8'h40;
  localparam logic [7:0] RCON_FWD_INIT = 8'h01;
  localparam logic [7:0] POLY_LO_DEF = 8'h1B;

  typedef enum logic {IDLE, RUN} state_t;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b, input logic [7:0] poly);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

  // Divide by x modulo the AES polynomial (inverse of xtime).
  function automatic logic [7:0] ixtime(input logic [7:0] b, input logic [7:0] poly);
    return b[0] ? (((b ^ poly) >> 1) | 8'h80) : (b >> 1);
  endfunction

  // Index of the final word for a key size (illegal sizes never reach RUN).
  function automatic logic [3:0] last_idx(input logic [1:0] ks);
    case (ks)
      KS_192:  return LEN_192 - 4'd1;
      KS_256:  return LEN_256 - 4'd1;
      default: return LEN_128 - 4'd1;
    endcase
  endfunction

  // First constant emitted: 0x01 forward, the last forward constant for inverse.
  function automatic logic [7:0] first_byte(input logic [1:0] ks, input logic inv);
    if (!inv) return RCON_FWD_INIT;
    case (ks)
      KS_192:  return RCON_INV_192;
      KS_256:  return RCON_INV_256;
      default: return RCON_INV_128;
    endcase
  endfunction

endpackage

// File: rtl/gf8_step.sv
// Combinational GF(2^8) stepper: multiply or divide a byte by x.
module gf8_step
  import aes_rcon_pkg::*;
#(
  parameter logic [7:0] POLY_LO = POLY_LO_DEF
) (
  input  logic [7:0] b,
  input  logic       inv,
  output logic [7:0] y
);

  assign y = inv ? ixtime(b, POLY_LO) : xtime(b, POLY_LO);

endmodule

// File: rtl/aes_rcon_seq.sv
// Sequential AES round-constant generator with valid/ready output stream.
module aes_rcon_seq
  import aes_rcon_pkg::*;
#(
  parameter int         WORD_W  = 32,
  parameter logic [7:0] POLY_LO = POLY_LO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        key_size,
  input  logic              inv,
  input  logic              rcon_ready,
  output logic              rcon_valid,
  output logic [WORD_W-1:0] rcon_word,
  output logic              rcon_last,
  output logic [3:0]        round_idx,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  state_t     state_q, state_d;
  logic [1:0] ks_q, ks_d;
  logic       inv_q, inv_d;
  logic [7:0] byte_q, byte_d, step_b;
  logic [3:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       cfg_err_q, cfg_err_d;
  logic       do_load, do_clear, take_start;

  gf8_step #(.POLY_LO(POLY_LO)) u_step (
    .b  (byte_q),
    .inv(inv_q),
    .y  (step_b)
  );

  // Next-state logic. A start arriving with the final accept is honoured so a
  // new sequence can follow back-to-back with the done pulse.
  always_comb begin
    state_d    = state_q;
    ks_d       = ks_q;
    inv_d      = inv_q;
    byte_d     = byte_q;
    idx_d      = idx_q;
    last_d     = last_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;
    do_load    = 1'b0;
    do_clear   = 1'b0;
    take_start = 1'b0;

    case (state_q)
      IDLE: take_start = start && !abort;
      RUN: begin
        if (abort) begin
          do_clear = 1'b1;
        end else if (rcon_ready) begin
          if (last_q) begin
            do_clear   = 1'b1;
            done_d     = 1'b1;
            take_start = start;
          end else begin
            idx_d  = idx_q + 4'd1;
            byte_d = step_b;
            last_d = ((idx_q + 4'd1) == last_idx(ks_q));
          end
        end
      end
      default: do_clear = 1'b1;
    endcase

    if (take_start) begin
      if (key_size == KS_ILL) cfg_err_d = 1'b1;
      else                    do_load   = 1'b1;
    end

    if (do_clear) begin
      state_d = IDLE;
      byte_d  = 8'h00;
      idx_d   = 4'd0;
      last_d  = 1'b0;
    end

    if (do_load) begin
      state_d = RUN;
      ks_d    = key_size;
      inv_d   = inv;
      byte_d  = first_byte(key_size, inv);
      idx_d   = 4'd0;
      last_d  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ks_q      <= KS_128;
      inv_q     <= 1'b0;
      byte_q    <= 8'h00;
      idx_q     <= 4'd0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ks_q      <= ks_d;
      inv_q     <= inv_d;
      byte_q    <= byte_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Place the constant byte in the top of the word; byte_q is zero in IDLE.
  always_comb begin
    rcon_word = '0;
    rcon_word[WORD_W-1 -: 8] = byte_q;
  end

  assign rcon_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign rcon_last  = last_q;
  assign round_idx  = idx_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
// Self-checking bench for aes_rcon_seq: table-driven sequences plus corner cases.
module tb_aes_rcon_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, inv, rcon_ready;
  logic [1:0]  key_size;
  logic        rcon_valid, rcon_last, busy, done, cfg_err;
  logic [31:0] rcon_word;
  logic [3:0]  round_idx;

  aes_rcon_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .key_size(key_size),
    .inv(inv), .rcon_ready(rcon_ready), .rcon_valid(rcon_valid),
    .rcon_word(rcon_word), .rcon_last(rcon_last), .round_idx(round_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       ks;
    logic             inv;
    int               n;
    logic [9:0][7:0]  b;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_valid"}, 32'(rcon_valid), 32'd0);
    chk({name, "_word"},  rcon_word,       32'd0);
    chk({name, "_last"},  32'(rcon_last),  32'd0);
    chk({name, "_idx"},   32'(round_idx),  32'd0);
    chk({name, "_busy"},  32'(busy),       32'd0);
  endtask

  task automatic push_vec(input int v);
    exp_t e;
    for (int i = 0; i < vecs[v].n; i++) begin
      e.word = {vecs[v].b[i], 24'h0};
      e.idx  = 4'(i);
      e.last = (i == vecs[v].n - 1);
      sb.push_back(e);
    end
  endtask

  // Runs one sequence from the table. started=1 means the first word is already
  // on the outputs. mid_start pulses an illegal-for-this-run start mid-sequence;
  // chain_v >= 0 issues the next start together with the final accept.
  task automatic run_seq(input int v, input bit rnd, input bit mid_start,
                         input int chain_v, input bit started);
    exp_t e;
    int   acc = 0;
    bit   stalled = 0, fin = 0;
    logic [31:0] prev_word = 32'h0;
    if (!started) begin
      push_vec(v);
      @(negedge clk);
      start = 1'b1; key_size = vecs[v].ks; inv = vecs[v].inv;
      @(negedge clk);
      start = 1'b0;
      chk("first_valid", 32'(rcon_valid), 32'd1);
      chk("first_busy",  32'(busy),       32'd1);
    end
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      start = 1'b0;
      rcon_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      if (!rcon_valid) begin
        chk("valid_dropped", 32'(rcon_valid), 32'd1);
        break;
      end
      if (stalled) chk("stable_word", rcon_word, prev_word);
      if (rcon_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 32'(sb.size()), 32'd1);
          break;
        end
        e = sb.pop_front();
        chk("word", rcon_word, e.word);
        chk("idx",  32'(round_idx), 32'(e.idx));
        chk("last", 32'(rcon_last), 32'(e.last));
        acc++;
        if (mid_start && acc == 2) begin
          start = 1'b1; key_size = 2'b10; inv = ~vecs[v].inv;
        end
        if (e.last) begin
          fin = 1;
          if (chain_v >= 0) begin
            start = 1'b1; key_size = vecs[chain_v].ks; inv = vecs[chain_v].inv;
            push_vec(chain_v);
          end
        end
        stalled = 0;
      end else begin
        stalled = 1;
        prev_word = rcon_word;
      end
      @(negedge clk);
    end
    start = 1'b0;
    rcon_ready = 1'b0;
    if (!fin) begin
      chk("seq_timeout", 32'd0, 32'd1);
      return;
    end
    chk("done_pulse", 32'(done), 32'd1);
    if (chain_v >= 0) begin
      chk("chain_valid", 32'(rcon_valid), 32'd1);
      chk("chain_idx",   32'(round_idx),  32'd0);
      chk("chain_word",  rcon_word, {vecs[chain_v].b[0], 24'h0});
    end else begin
      chk_idle("after_last");
      @(negedge clk);
      chk("done_single", 32'(done), 32'd0);
    end
  endtask

  initial begin
    vecs[0].ks = 2'b00; vecs[0].inv = 1'b0; vecs[0].n = 10;
    {vecs[0].b[0], vecs[0].b[1], vecs[0].b[2], vecs[0].b[3], vecs[0].b[4],
     vecs[0].b[5], vecs[0].b[6], vecs[0].b[7], vecs[0].b[8], vecs[0].b[9]} =
      {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    vecs[1].ks = 2'b00; vecs[1].inv = 1'b1; vecs[1].n = 10;
    {vecs[1].b[0], vecs[1].b[1], vecs[1].b[2], vecs[1].b[3], vecs[1].b[4],
     vecs[1].b[5], vecs[1].b[6], vecs[1].b[7], vecs[1].b[8], vecs[1].b[9]} =
      {8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    vecs[2].ks = 2'b01; vecs[2].inv = 1'b1; vecs[2].n = 8; vecs[2].b = '0;
    {vecs[2].b[0], vecs[2].b[1], vecs[2].b[2], vecs[2].b[3], vecs[2].b[4],
     vecs[2].b[5], vecs[2].b[6], vecs[2].b[7]} =
      {8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    vecs[3].ks = 2'b10; vecs[3].inv = 1'b1; vecs[3].n = 7; vecs[3].b = '0;
    {vecs[3].b[0], vecs[3].b[1], vecs[3].b[2], vecs[3].b[3], vecs[3].b[4],
     vecs[3].b[5], vecs[3].b[6]} =
      {8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    vecs[4].ks = 2'b10; vecs[4].inv = 1'b0; vecs[4].n = 7; vecs[4].b = '0;
    {vecs[4].b[0], vecs[4].b[1], vecs[4].b[2], vecs[4].b[3], vecs[4].b[4],
     vecs[4].b[5], vecs[4].b[6]} =
      {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
    vecs[5].ks = 2'b01; vecs[5].inv = 1'b0; vecs[5].n = 8; vecs[5].b = '0;
    {vecs[5].b[0], vecs[5].b[1], vecs[5].b[2], vecs[5].b[3], vecs[5].b[4],
     vecs[5].b[5], vecs[5].b[6], vecs[5].b[7]} =
      {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    rst = 1'b1; start = 1'b0; abort = 1'b0; inv = 1'b0; key_size = 2'b00; rcon_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("reset");
    chk("reset_done",    32'(done),    32'd0);
    chk("reset_cfg_err", 32'(cfg_err), 32'd0);
    rst = 1'b0;

    // Table: every key size and direction with ready held high.
    for (int v = 0; v < 6; v++) run_seq(v, 1'b0, 1'b0, -1, 1'b0);

    // Backpressure on AES-256 forward.
    run_seq(4, 1'b1, 1'b0, -1, 1'b0);
    run_seq(1, 1'b1, 1'b0, -1, 1'b0);

    // Abort at round_idx 3 of AES-192 forward with a simultaneous accept.
    @(negedge clk);
    start = 1'b1; key_size = 2'b01; inv = 1'b0; rcon_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_idx", 32'(round_idx), 32'd3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; rcon_ready = 1'b0;
    chk_idle("abort");
    chk("abort_no_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abort_no_done2", 32'(done), 32'd0);
    run_seq(5, 1'b0, 1'b0, -1, 1'b0);

    // Abort in IDLE beats a start.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; key_size = 2'b11;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_valid", 32'(rcon_valid), 32'd0);
    chk("idle_abort_cfg",   32'(cfg_err),    32'd0);

    // Illegal key size.
    start = 1'b1; key_size = 2'b11;
    @(negedge clk);
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err),    32'd1);
    chk("cfg_err_valid", 32'(rcon_valid), 32'd0);
    @(negedge clk);
    chk("cfg_err_single", 32'(cfg_err),   32'd0);
    chk("cfg_err_idle",   32'(rcon_valid), 32'd0);

    // Start during RUN is ignored.
    run_seq(0, 1'b0, 1'b1, -1, 1'b0);

    // Reset mid-sequence.
    @(negedge clk);
    start = 1'b1; key_size = 2'b10; inv = 1'b0; rcon_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rcon_ready = 1'b0;
    chk_idle("mid_reset");
    chk("mid_reset_done", 32'(done), 32'd0);

    // Start together with the final accept: done and new first word coincide.
    run_seq(0, 1'b0, 1'b0, 3, 1'b0);
    run_seq(3, 1'b0, 1'b0, -1, 1'b1);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
